// File: rtl/alu_cmd_driver.sv
// Command FIFO plus IDLE/EXEC/RESP sequencer that drives an external 4-bit ALU and
// returns tagged, in-order results; divide-by-zero is answered locally with an error flag.
module alu_cmd_driver #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [2:0]       i_cmd_sel,
    input  logic [3:0]       i_cmd_a,
    input  logic [3:0]       i_cmd_b,
    input  logic [TAG_W-1:0] i_cmd_tag,
    output logic [3:0]       o_alu_a,
    output logic [3:0]       o_alu_b,
    output logic [2:0]       o_alu_sel,
    input  logic [7:0]       i_alu_out,
    input  logic             i_alu_carry,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [7:0]       o_rsp_data,
    output logic             o_rsp_carry,
    output logic             o_rsp_err,
    output logic [TAG_W-1:0] o_rsp_tag,
    output logic             o_busy,
    output logic [15:0]      o_op_count
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e           r_state;
    state_e           w_state_next;

    logic [2:0]       r_mem_sel [DEPTH];
    logic [3:0]       r_mem_a   [DEPTH];
    logic [3:0]       r_mem_b   [DEPTH];
    logic [TAG_W-1:0] r_mem_tag [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic [3:0]       r_alu_a;
    logic [3:0]       r_alu_b;
    logic [2:0]       r_alu_sel;
    logic [TAG_W-1:0] r_tag;
    logic             r_rsp_valid;
    logic [7:0]       r_rsp_data;
    logic             r_rsp_carry;
    logic             r_rsp_err;
    logic [TAG_W-1:0] r_rsp_tag;
    logic [15:0]      r_op_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_capture;
    logic w_rsp_done;
    logic w_div_zero;

    assign w_full      = (r_count == (AW + 1)'(DEPTH));
    assign w_empty     = (r_count == '0);
    // Ready is masked by reset so nothing is accepted while the block is held.
    assign o_cmd_ready = i_rst_n && !w_full;
    assign w_push      = i_cmd_valid && o_cmd_ready;
    assign w_div_zero  = (r_alu_sel == 3'b011) && (r_alu_b == 4'd0);

    // FIFO storage; contents are never reset, only the pointers are.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_sel[r_wr_ptr] <= i_cmd_sel;
            r_mem_a[r_wr_ptr]   <= i_cmd_a;
            r_mem_b[r_wr_ptr]   <= i_cmd_b;
            r_mem_tag[r_wr_ptr] <= i_cmd_tag;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW + 1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (AW + 1)'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (!w_empty) w_state_next = StExec;
            StExec: w_state_next = StResp;
            StResp: if (i_rsp_ready) w_state_next = w_empty ? StIdle : StExec;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_pop      = 1'b0;
        w_capture  = 1'b0;
        w_rsp_done = 1'b0;
        unique case (r_state)
            StIdle: w_pop = !w_empty;
            StExec: w_capture = 1'b1;
            StResp: begin
                w_rsp_done = i_rsp_ready;
                w_pop      = i_rsp_ready && !w_empty;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_sel   <= '0;
            r_tag       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_carry <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_tag   <= '0;
            r_op_count  <= '0;
        end else begin
            if (w_pop) begin
                r_alu_a   <= r_mem_a[r_rd_ptr];
                r_alu_b   <= r_mem_b[r_rd_ptr];
                r_alu_sel <= r_mem_sel[r_rd_ptr];
                r_tag     <= r_mem_tag[r_rd_ptr];
            end
            if (w_capture) begin
                // The ALU quotient is undefined for b=0, so substitute a fixed error result.
                if (w_div_zero) begin
                    r_rsp_data  <= 8'hFF;
                    r_rsp_carry <= 1'b0;
                    r_rsp_err   <= 1'b1;
                end else begin
                    r_rsp_data  <= i_alu_out;
                    r_rsp_carry <= i_alu_carry;
                    r_rsp_err   <= 1'b0;
                end
                r_rsp_valid <= 1'b1;
                r_rsp_tag   <= r_tag;
            end
            if (w_rsp_done) begin
                r_rsp_valid <= 1'b0;
                r_op_count  <= r_op_count + 16'd1;
            end
        end
    end

    assign o_alu_a     = r_alu_a;
    assign o_alu_b     = r_alu_b;
    assign o_alu_sel   = r_alu_sel;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_carry = r_rsp_carry;
    assign o_rsp_err   = r_rsp_err;
    assign o_rsp_tag   = r_rsp_tag;
    assign o_op_count  = r_op_count;
    assign o_busy      = !w_empty || (r_state != StIdle);

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Randomized and directed bench for alu_cmd_driver; a queue-based transaction model predicts
// every output each cycle, and a behavioural ALU closes the loop on the operand interface.
module tb_alu_cmd_driver;
    localparam int DEPTH = 4;
    localparam int TAG_W = 2;

    typedef struct {
        logic [2:0]       sel;
        logic [3:0]       a;
        logic [3:0]       b;
        logic [TAG_W-1:0] tag;
        bit               has_lit;
        logic [7:0]       lit;
    } cmd_t;

    logic clk;
    logic rst_n;
    logic cmd_valid;
    logic cmd_ready;
    cmd_t tb_cmd;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_sel;
    logic [7:0] alu_out;
    logic alu_carry;
    logic rsp_valid, rsp_ready, rsp_carry, rsp_err, busy;
    logic [7:0] rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic [15:0] op_count;

    int n_chk = 0;
    int n_err = 0;

    alu_cmd_driver #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_sel(tb_cmd.sel), .i_cmd_a(tb_cmd.a), .i_cmd_b(tb_cmd.b), .i_cmd_tag(tb_cmd.tag),
        .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_sel(alu_sel),
        .i_alu_out(alu_out), .i_alu_carry(alu_carry),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_data(rsp_data), .o_rsp_carry(rsp_carry), .o_rsp_err(rsp_err),
        .o_rsp_tag(rsp_tag), .o_busy(busy), .o_op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic meaning of each select; returns {carry, result}.
    function automatic logic [8:0] alu_fn(input logic [2:0] s, input logic [3:0] a,
                                          input logic [3:0] b);
        logic [7:0] ea, eb, sum;
        ea = {4'h0, a};
        eb = {4'h0, b};
        case (s)
            3'd0: begin sum = ea + eb; return {sum[4], sum}; end
            3'd1: return {(a < b), ea - eb};
            3'd2: return {1'b0, ea * eb};
            3'd3: return (b == 4'd0) ? 9'h0 : {1'b0, ea / eb};
            3'd4: return {1'b0, ea & eb};
            3'd5: return {1'b0, ea | eb};
            3'd6: return {1'b0, ~(ea & eb)};
            default: return {1'b0, ea ^ eb};
        endcase
    endfunction

    // External ALU; garbage on divide-by-zero proves the driver ignores it.
    always_comb begin
        if (alu_sel == 3'b011 && alu_b == 4'd0) {alu_carry, alu_out} = 9'h1AA;
        else {alu_carry, alu_out} = alu_fn(alu_sel, alu_a, alu_b);
    end

    // Transaction model: pending queue, current command, and response phase.
    cmd_t m_q[$];
    cmd_t m_cur;
    int   m_phase = 0;  // 0 idle, 1 executing, 2 response offered
    bit   m_acc;
    logic [TAG_W-1:0] m_next_tag = '0;
    logic m_rsp_valid = 0, m_rsp_carry = 0, m_rsp_err = 0;
    logic [7:0] m_rsp_data = 0;
    logic [TAG_W-1:0] m_rsp_tag = 0;
    logic [3:0] m_alu_a = 0, m_alu_b = 0;
    logic [2:0] m_alu_sel = 0;
    logic [15:0] m_op_count = 0;
    bit m_lit_has = 0;
    logic [7:0] m_lit = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit do_pop;
        logic [8:0] r;
        m_acc = 0;
        if (!rst_n) begin
            m_q.delete();
            m_phase = 0;
            m_rsp_valid = 0; m_rsp_data = 0; m_rsp_carry = 0; m_rsp_err = 0; m_rsp_tag = 0;
            m_alu_a = 0; m_alu_b = 0; m_alu_sel = 0; m_op_count = 0; m_lit_has = 0;
            return;
        end
        m_acc = cmd_valid && (m_q.size() < DEPTH);
        do_pop = 0;
        case (m_phase)
            0: if (m_q.size() > 0) do_pop = 1;
            1: begin
                if (m_cur.sel == 3'b011 && m_cur.b == 4'd0) begin
                    m_rsp_data = 8'hFF; m_rsp_carry = 0; m_rsp_err = 1;
                end else begin
                    r = alu_fn(m_cur.sel, m_cur.a, m_cur.b);
                    m_rsp_data = r[7:0]; m_rsp_carry = r[8]; m_rsp_err = 0;
                end
                m_rsp_valid = 1;
                m_rsp_tag = m_cur.tag;
                m_lit_has = m_cur.has_lit;
                m_lit = m_cur.lit;
                m_phase = 2;
            end
            default: if (rsp_ready) begin
                m_rsp_valid = 0;
                m_op_count = m_op_count + 16'd1;
                m_phase = 0;
                if (m_q.size() > 0) do_pop = 1;
            end
        endcase
        if (do_pop) begin
            m_cur = m_q.pop_front();
            m_alu_a = m_cur.a; m_alu_b = m_cur.b; m_alu_sel = m_cur.sel;
            m_phase = 1;
        end
        if (m_acc) begin
            m_q.push_back(tb_cmd);
            m_next_tag = m_next_tag + 1'b1;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_eq("cmd_ready", cmd_ready, rst_n && (m_q.size() < DEPTH));
        check_eq("rsp_valid", rsp_valid, m_rsp_valid);
        check_eq("rsp_data", rsp_data, m_rsp_data);
        check_eq("rsp_carry", rsp_carry, m_rsp_carry);
        check_eq("rsp_err", rsp_err, m_rsp_err);
        check_eq("rsp_tag", rsp_tag, m_rsp_tag);
        check_eq("alu_ops", {alu_sel, alu_a, alu_b}, {m_alu_sel, m_alu_a, m_alu_b});
        check_eq("op_count", op_count, m_op_count);
        check_eq("busy", busy, (m_q.size() > 0) || (m_phase != 0));
        if (m_rsp_valid && m_lit_has) check_eq("lit_data", rsp_data, m_lit);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    function automatic cmd_t mk(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b,
                                input bit has, input logic [7:0] lit);
        cmd_t c;
        c.sel = s; c.a = a; c.b = b; c.tag = '0; c.has_lit = has; c.lit = lit;
        return c;
    endfunction

    task automatic send(input cmd_t c);
        bit done;
        done = 0;
        tb_cmd = c;
        tb_cmd.tag = m_next_tag;
        cmd_valid = 1;
        for (int i = 0; i < 50 && !done; i++) begin
            cycle();
            done = m_acc;
        end
        if (!done) check_eq("send_timeout", 0, 1);
        cmd_valid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int accepted;
        rst_n = 0; cmd_valid = 0; rsp_ready = 1;
        tb_cmd = mk(3'd0, 4'd0, 4'd0, 0, 8'h0);
        run(2);
        rst_n = 1;
        run(1);

        // Single add and first-response latency.
        send(mk(3'd0, 4'd9, 4'd8, 1, 8'h11));
        run(5);
        check_eq("add_opcount", op_count, 1);

        // Divide by zero, then a legal divide.
        send(mk(3'd3, 4'd7, 4'd0, 1, 8'hFF));
        send(mk(3'd3, 4'd9, 4'd2, 1, 8'h04));
        run(8);

        // Backpressure: one in flight plus a full FIFO.
        rsp_ready = 0;
        send(mk(3'd2, 4'hF, 4'hF, 1, 8'hE1));
        send(mk(3'd1, 4'd3, 4'd5, 1, 8'hFE));
        send(mk(3'd7, 4'hA, 4'd5, 1, 8'h0F));
        send(mk(3'd6, 4'hF, 4'hF, 1, 8'hF0));
        send(mk(3'd5, 4'd1, 4'd2, 1, 8'h03));
        check_eq("bp_full_ready", cmd_ready, 0);
        run(4);
        rsp_ready = 1;
        run(12);

        // Random stream with random backpressure.
        accepted = 0;
        tb_cmd = mk(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom_range(0, 15)), 0, 8'h0);
        tb_cmd.tag = m_next_tag;
        for (int i = 0; i < 400 && accepted < 16; i++) begin
            cmd_valid = ($urandom_range(0, 3) != 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
            if (m_acc) begin
                accepted++;
                tb_cmd = mk(3'($urandom_range(0, 7)), 4'($urandom),
                            4'($urandom_range(0, 15)), 0, 8'h0);
                tb_cmd.tag = m_next_tag;
            end
        end
        check_eq("rand_accepted", accepted, 16);
        cmd_valid = 0; rsp_ready = 1;
        run(12);

        // Reset while executing with three commands queued.
        rsp_ready = 0;
        for (int i = 0; i < 4; i++) send(mk(3'd0, 4'(i), 4'd1, 0, 8'h0));
        run(1);
        rsp_ready = 1;
        send(mk(3'd4, 4'hC, 4'hA, 0, 8'h0));
        rst_n = 0;
        run(1);
        rst_n = 1;
        run(1);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_cmd_ready", cmd_ready, 1);
        run(5);

        // op_count wrap from its maximum.
        force dut.r_op_count = 16'hFFFF;
        #1;
        release dut.r_op_count;
        m_op_count = 16'hFFFF;
        send(mk(3'd0, 4'd1, 4'd1, 1, 8'h02));
        run(5);
        check_eq("opcount_wrap", op_count, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
